zigzag_quantizer: RTL and testbench

Quantizes the zig-zag-ordered DCT coefficient stream leaving `fdct_zigzag` and feeds the run-length coder. It accepts one 12-bit signed coefficient per enabled cycle and tracks the 64-coefficient block position. Each coefficient is multiplied by a per-position reciprocal quantizer value from a host-loadable 64-entry table. The result is rounded, saturated and emitted with block framing after a fixed 3-cycle pipeline.

---
 rtl/jpeg_quant_pkg.sv | 26 ++
 rtl/zigzag_quantizer_if.sv | 25 ++
 rtl/zq_recip_table.sv | 38 +++
 rtl/zigzag_quantizer.sv | 157 +++++++++++++++
 tb/tb_zigzag_quantizer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_quant_pkg.sv
// Shared constants and types for the zig-zag coefficient quantizer.
//   COEF_W   : input coefficient width (two's complement)
//   QOUT_W   : quantized output width (two's complement)
//   RECIP_W  : unsigned reciprocal width, value = round(2^16 / q)
//   IDX_W    : zig-zag index width; BLK_LEN coefficients per block
package jpeg_quant_pkg;

  localparam int unsigned COEF_W  = 12;
  localparam int unsigned QOUT_W  = 11;
  localparam int unsigned RECIP_W = 17;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned BLK_LEN = 64;

  // Signed product width: coefficient times zero-extended reciprocal.
  localparam int unsigned PROD_W = COEF_W + RECIP_W + 1;

  localparam logic [RECIP_W-1:0] RECIP_ONE  = 17'h10000;
  localparam int unsigned        ROUND_HALF = 1 << 15;
  localparam int unsigned        QMAX       = 1023;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BLOCK = 1'b1
  } zq_state_t;

endpackage

// File: rtl/zigzag_quantizer_if.sv
// Coefficient stream in / quantized stream out of the zig-zag quantizer.
//   master : stream producer / result consumer (drives din side)
//   slave  : the quantizer (drives dout side)
interface zigzag_quantizer_if;

  logic                                      din_valid;
  logic                                      dstrb;
  logic signed [jpeg_quant_pkg::COEF_W-1:0]  din;
  logic                                      dout_valid;
  logic signed [jpeg_quant_pkg::QOUT_W-1:0]  dout;
  logic        [jpeg_quant_pkg::IDX_W-1:0]   dout_idx;
  logic                                      dout_sob;
  logic                                      dout_eob;

  modport master (
    output din_valid, dstrb, din,
    input  dout_valid, dout, dout_idx, dout_sob, dout_eob
  );

  modport slave (
    input  din_valid, dstrb, din,
    output dout_valid, dout, dout_idx, dout_sob, dout_eob
  );

endinterface

// File: rtl/zq_recip_table.sv
// 64-entry reciprocal quantizer table held in flops.
//   clk, rst : clock, synchronous active-high reset (all entries -> RECIP_ONE)
//   ena      : clock enable for writes and the read register
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : registered read; a same-cycle write to raddr is not seen
module zq_recip_table
  import jpeg_quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [RECIP_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [RECIP_W-1:0] rdata
);

  logic [RECIP_W-1:0] mem_q [BLK_LEN];
  logic [RECIP_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLK_LEN; i++) begin
        mem_q[i] <= RECIP_ONE;
      end
      rdata_q <= '0;
    end else if (ena) begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/zigzag_quantizer.sv
// Quantizes a zig-zag-ordered DCT coefficient stream with a per-position
// reciprocal table, rounding half away from zero and saturating to +/-1023.
//   clk, rst  : clock, synchronous active-high reset
//   ena       : global clock enable, low freezes every register
//   bus       : coefficient stream in (din_valid/dstrb/din) and quantized
//               stream out (dout_valid/dout/dout_idx/dout_sob/dout_eob)
//   qt_we/qt_addr/qt_data : reciprocal table write port
//   sync_err  : sticky framing error, cleared only by rst
// Pipeline: S1 din/idx/table read, S2 product, S3 rounded result and flags.
module zigzag_quantizer
  import jpeg_quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  zigzag_quantizer_if.slave  bus,
  input  logic               qt_we,
  input  logic [IDX_W-1:0]   qt_addr,
  input  logic [RECIP_W-1:0] qt_data,
  output logic               sync_err
);

  // Input framing FSM.
  zq_state_t        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sync_err_q, sync_err_d;
  logic             acc;
  logic [IDX_W-1:0] acc_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = sync_err_q;
    acc        = 1'b0;
    acc_idx    = cnt_q;
    if (bus.din_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.dstrb) begin
            acc     = 1'b1;
            acc_idx = '0;
            cnt_d   = IDX_W'(1);
            state_d = BLOCK;
          end else begin
            // Coefficient outside a block is dropped.
            sync_err_d = 1'b1;
          end
        end
        BLOCK: begin
          if (bus.dstrb) begin
            // Early strobe: flag it and restart the block on this coefficient.
            sync_err_d = 1'b1;
            acc        = 1'b1;
            acc_idx    = '0;
            cnt_d      = IDX_W'(1);
          end else begin
            acc     = 1'b1;
            acc_idx = cnt_q;
            cnt_d   = cnt_q + IDX_W'(1);  // wraps 63 -> 0
            if (cnt_q == IDX_W'(BLK_LEN - 1)) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reciprocal table; its read register forms part of S1.
  logic [RECIP_W-1:0] recip;

  zq_recip_table u_recip_table (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .we    (qt_we),
    .waddr (qt_addr),
    .wdata (qt_data),
    .raddr (acc_idx),
    .rdata (recip)
  );

  // Datapath registers.
  logic                     s1_valid_q;
  logic signed [COEF_W-1:0] s1_din_q;
  logic [IDX_W-1:0]         s1_idx_q;
  logic                     s2_valid_q;
  logic signed [PROD_W-1:0] s2_prod_q;
  logic [IDX_W-1:0]         s2_idx_q;
  logic                     s3_valid_q;
  logic signed [QOUT_W-1:0] s3_dout_q;
  logic [IDX_W-1:0]         s3_idx_q;
  logic                     s3_sob_q;
  logic                     s3_eob_q;

  // S2 input: reciprocal is zero-extended so the product stays signed.
  logic signed [PROD_W-1:0] prod;
  assign prod = PROD_W'(s1_din_q) * PROD_W'($signed({1'b0, recip}));

  // S3 input: round magnitude half away from zero, saturate, reapply sign.
  logic [PROD_W-1:0]    mag;
  logic [PROD_W-1:0]    rnd;
  logic [PROD_W-17:0]   mq;
  logic [QOUT_W-1:0]    qabs;
  logic signed [QOUT_W-1:0] qout;

  always_comb begin
    mag  = s2_prod_q[PROD_W-1] ? $unsigned(-s2_prod_q) : $unsigned(s2_prod_q);
    rnd  = mag + PROD_W'(ROUND_HALF);
    mq   = rnd[PROD_W-1:16];
    qabs = (mq > (PROD_W-16)'(QMAX)) ? QOUT_W'(QMAX) : mq[QOUT_W-1:0];
    qout = s2_prod_q[PROD_W-1] ? $signed(-qabs) : $signed(qabs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_din_q   <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_idx_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_dout_q  <= '0;
      s3_idx_q   <= '0;
      s3_sob_q   <= 1'b0;
      s3_eob_q   <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
      s1_valid_q <= acc;
      s1_din_q   <= bus.din;
      s1_idx_q   <= acc_idx;
      s2_valid_q <= s1_valid_q;
      s2_prod_q  <= prod;
      s2_idx_q   <= s1_idx_q;
      s3_valid_q <= s2_valid_q;
      s3_dout_q  <= qout;
      s3_idx_q   <= s2_idx_q;
      s3_sob_q   <= s2_valid_q && (s2_idx_q == '0);
      s3_eob_q   <= s2_valid_q && (s2_idx_q == IDX_W'(BLK_LEN - 1));
    end
  end

  assign bus.dout_valid = s3_valid_q;
  assign bus.dout       = s3_dout_q;
  assign bus.dout_idx   = s3_idx_q;
  assign bus.dout_sob   = s3_sob_q;
  assign bus.dout_eob   = s3_eob_q;
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_zigzag_quantizer.sv
module tb_zigzag_quantizer;
  import jpeg_quant_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena;
  logic               qt_we;
  logic [IDX_W-1:0]   qt_addr;
  logic [RECIP_W-1:0] qt_data;
  logic               sync_err;

  zigzag_quantizer_if bus ();

  zigzag_quantizer u_dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .bus      (bus),
    .qt_we    (qt_we),
    .qt_addr  (qt_addr),
    .qt_data  (qt_data),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int dout;
    int idx;
    int sob;
    int eob;
    int cyc;
    int stalls;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  int m_recip [64];
  bit m_block;
  int m_cnt;
  int cyc    = 0;
  int stalls = 0;
  int seed   = 7;
  int hz_idx = -1;
  int hz_data = 0;

  function automatic int model_quant(input int d, input int r);
    longint p, mag, m;
    p   = longint'(d) * longint'(r);
    mag = (p < 0) ? -p : p;
    m   = (mag + 32768) / 65536;
    if (m > 1023) m = 1023;
    return (p < 0) ? -int'(m) : int'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_recip[i] = 32'h10000;
    m_block = 0;
    m_cnt   = 0;
  endtask

  task automatic send(input bit strb, input int d);
    bit acc;
    int idx;
    bus.din_valid = 1'b1;
    bus.dstrb     = strb;
    bus.din       = d[COEF_W-1:0];
    acc = 0;
    idx = 0;
    if (!m_block) begin
      if (strb) begin
        acc = 1; idx = 0; m_cnt = 1; m_block = 1;
      end
    end else if (strb) begin
      acc = 1; idx = 0; m_cnt = 1;
    end else begin
      acc = 1; idx = m_cnt; m_cnt = (m_cnt + 1) % 64;
      if (idx == 63) m_block = 0;
    end
    if (acc) sb_q.push_back('{model_quant(d, m_recip[idx]), idx, int'(idx == 0),
                              int'(idx == 63), cyc, stalls});
    // Table write lands after this cycle's read.
    if (qt_we) m_recip[qt_addr] = int'(qt_data);
    tick();
    bus.din_valid = 1'b0;
    bus.dstrb     = 1'b0;
    qt_we         = 1'b0;
  endtask

  task automatic qt_write(input int a, input int d);
    qt_we   = 1'b1;
    qt_addr = a[IDX_W-1:0];
    qt_data = d[RECIP_W-1:0];
    m_recip[a] = d;
    tick();
    qt_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_dout_valid"}, int'(bus.dout_valid), 0);
    check_eq({pfx, "_dout"}, int'($signed(bus.dout)), 0);
    check_eq({pfx, "_dout_idx"}, int'(bus.dout_idx), 0);
    check_eq({pfx, "_dout_sob"}, int'(bus.dout_sob), 0);
    check_eq({pfx, "_dout_eob"}, int'(bus.dout_eob), 0);
    check_eq({pfx, "_sync_err"}, int'(sync_err), 0);
  endtask

  task automatic run_block(input int sp_idx, input int sp_val);
    int v;
    for (int i = 0; i < 64; i++) begin
      v = ((i * 53 + seed) % 4096) - 2048;
      if (i == sp_idx) v = sp_val;
      if (i == hz_idx) begin
        qt_we   = 1'b1;
        qt_addr = IDX_W'(hz_idx);
        qt_data = RECIP_W'(hz_data);
      end
      send(i == 0, v);
    end
    seed += 101;
  endtask

  // Cycle and stall bookkeeping for latency checks.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!ena) stalls++;
  end

  // Output monitor: consumes on ena & dout_valid, checks outputs hold while frozen.
  initial begin
    bit   prev_ena;
    int   l_dout, l_idx, l_valid;
    exp_t e;
    prev_ena = 1;
    l_dout = 0; l_idx = 0; l_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!prev_ena) begin
          check_eq("hold_dout", int'($signed(bus.dout)), l_dout);
          check_eq("hold_idx", int'(bus.dout_idx), l_idx);
          check_eq("hold_valid", int'(bus.dout_valid), l_valid);
        end
        if (ena && bus.dout_valid) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_out", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("dout", int'($signed(bus.dout)), e.dout);
            check_eq("dout_idx", int'(bus.dout_idx), e.idx);
            check_eq("dout_sob", int'(bus.dout_sob), e.sob);
            check_eq("dout_eob", int'(bus.dout_eob), e.eob);
            check_eq("latency", cyc - e.cyc - (stalls - e.stalls), 3);
          end
        end
      end
      prev_ena = ena;
      l_dout   = int'($signed(bus.dout));
      l_idx    = int'(bus.dout_idx);
      l_valid  = int'(bus.dout_valid);
    end
  end

  initial begin
    int id_vals [7];
    int v;
    id_vals = '{0, 1, -1, 1023, -1024, 2047, -2048};
    rst = 1'b1; ena = 1'b1; qt_we = 1'b0; qt_addr = '0; qt_data = '0;
    bus.din_valid = 1'b0; bus.dstrb = 1'b0; bus.din = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Identity table, with a 5-cycle enable stall mid-block.
    for (int i = 0; i < 64; i++) begin
      v = (i < 7) ? id_vals[i] : ((i * 37) % 4096) - 2048;
      if (i == 40) begin
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
      end
      send(i == 0, v);
    end
    check_eq("no_sync_err", int'(sync_err), 0);

    // Rounding with q = 2 at idx 5.
    qt_write(5, 32'h8000);
    run_block(5, 3);
    run_block(5, -3);
    run_block(5, 5);

    // Write/read hazard at idx 7: old value this block, new value next block.
    hz_idx = 7; hz_data = 32'h4000;
    run_block(7, 100);
    hz_idx = -1;
    run_block(7, 10);

    // Early strobe at idx 20 restarts the block.
    for (int i = 0; i < 20; i++) send(i == 0, i * 11 - 100);
    send(1'b1, 321);
    check_eq("sync_err_set", int'(sync_err), 1);
    for (int i = 1; i < 64; i++) send(1'b0, 500 - i * 13);
    run_block(-1, 0);
    check_eq("sync_err_sticky", int'(sync_err), 1);

    // Reset at idx 30 flushes the pipeline and restores the table.
    for (int i = 0; i < 30; i++) send(i == 0, i * 29 - 400);
    do_reset();
    check_idle_outputs("mid_reset");
    run_block(5, 3);
    check_eq("post_reset_no_err", int'(sync_err), 0);

    // Coefficient without strobe in IDLE is dropped.
    send(1'b0, 77);
    check_eq("idle_drop_err", int'(sync_err), 1);
    run_block(5, -5);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check_eq("drain", sb_q.size(), 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
